// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: three valid/ready producers share the register-file write port, round-robin.
// Optional macro WB_ARB_FWD_EN adds a combinational forwarding path from the registered write.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src0_valid_i,
    input  logic              src1_valid_i,
    input  logic              src2_valid_i,
    output logic              src0_ready_o,
    output logic              src1_ready_o,
    output logic              src2_ready_o,
    input  logic [ADDR_W-1:0] src0_rd_i,
    input  logic [ADDR_W-1:0] src1_rd_i,
    input  logic [ADDR_W-1:0] src2_rd_i,
    input  logic [DATA_W-1:0] src0_dat_i,
    input  logic [DATA_W-1:0] src1_dat_i,
    input  logic [DATA_W-1:0] src2_dat_i,
`ifdef WB_ARB_FWD_EN
    input  logic [ADDR_W-1:0] fwd_rs1_i,
    input  logic [ADDR_W-1:0] fwd_rs2_i,
    output logic              fwd_rs1_hit_o,
    output logic              fwd_rs2_hit_o,
    output logic [DATA_W-1:0] fwd_dat_o,
`endif
    output logic [ADDR_W-1:0] reg_des_o,
    output logic [DATA_W-1:0] reg_des_dat_o,
    output logic              wr_en_o,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    // Handshake: a source transfers on a rising edge where its valid and ready are both high;
    // valid never depends on ready, and rd/data stay stable until ready.
    logic [1:0]        ptr_q, ptr_d;
    logic [2:0]        valid, gnt;
    logic [1:0]        gnt_idx;
    logic              gnt_any;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_dat;
    logic [ADDR_W-1:0] reg_des_q;
    logic [DATA_W-1:0] reg_des_dat_q;
    logic              wr_en_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              multi;

    assign valid = {src2_valid_i, src1_valid_i, src0_valid_i};

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr_q;
        gnt_any = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int s;
            s = int'(ptr_q) + k;
            if (s >= 3) s = s - 3;
            if (!gnt_any && valid[s]) begin
                gnt_any = 1'b1;
                gnt_idx = 2'(s);
                gnt[s]  = 1'b1;
            end
        end
    end

    // Readies are masked while reset is asserted so nothing is accepted.
    assign src0_ready_o = gnt[0] & rst_n;
    assign src1_ready_o = gnt[1] & rst_n;
    assign src2_ready_o = gnt[2] & rst_n;

    always_comb begin
        sel_rd  = src0_rd_i;
        sel_dat = src0_dat_i;
        case (gnt_idx)
            2'd1: begin
                sel_rd  = src1_rd_i;
                sel_dat = src1_dat_i;
            end
            2'd2: begin
                sel_rd  = src2_rd_i;
                sel_dat = src2_dat_i;
            end
            default: begin
                sel_rd  = src0_rd_i;
                sel_dat = src0_dat_i;
            end
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end

    assign multi = (src0_valid_i & src1_valid_i) | (src0_valid_i & src2_valid_i)
                 | (src1_valid_i & src2_valid_i);

    always_comb begin
        cnt_d = cnt_q;
        if (multi && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= 2'd0;
            reg_des_q     <= '0;
            reg_des_dat_q <= '0;
            wr_en_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (gnt_any) begin
                reg_des_q     <= sel_rd;
                reg_des_dat_q <= sel_dat;
                // x0 writes are accepted but never reach the register file.
                wr_en_q       <= (sel_rd != '0);
            end else begin
                wr_en_q <= 1'b0;
            end
        end
    end

    assign reg_des_o      = reg_des_q;
    assign reg_des_dat_o  = reg_des_dat_q;
    assign wr_en_o        = wr_en_q;
    assign conflict_cnt_o = cnt_q;

`ifdef WB_ARB_FWD_EN
    assign fwd_rs1_hit_o = wr_en_q && (fwd_rs1_i == reg_des_q) && (fwd_rs1_i != '0);
    assign fwd_rs2_hit_o = wr_en_q && (fwd_rs2_i == reg_des_q) && (fwd_rs2_i != '0);
    assign fwd_dat_o     = reg_des_dat_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table plus hand sequences, write-port scoreboard.
// A second instance with CNT_W=4 shares the inputs to check counter saturation.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;
    localparam int QW = 1 + AW + DW + CW;

    logic          clk;
    logic          rst_n;
    logic [2:0]    vld;
    logic [AW-1:0] src_rd  [3];
    logic [DW-1:0] src_dat [3];
    logic [2:0]    rdy, rdy4;
    logic [AW-1:0] reg_des, reg_des4;
    logic [DW-1:0] reg_dat, reg_dat4;
    logic          wr_en, wr_en4;
    logic [CW-1:0] cnt;
    logic [3:0]    cnt4;
`ifdef WB_ARB_FWD_EN
    logic [AW-1:0] fwd_rs1, fwd_rs2;
    logic          hit1, hit2, hit1_4, hit2_4;
    logic [DW-1:0] fwd_dat, fwd_dat4;
`endif

    int checks = 0;
    int errors = 0;
    logic [QW-1:0] exp_q[$];

    // bench-side view of the registered write port
    logic          m_we;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_dat;
    int            m_cnt;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .src0_valid_i(vld[0]), .src1_valid_i(vld[1]), .src2_valid_i(vld[2]),
        .src0_ready_o(rdy[0]), .src1_ready_o(rdy[1]), .src2_ready_o(rdy[2]),
        .src0_rd_i(src_rd[0]), .src1_rd_i(src_rd[1]), .src2_rd_i(src_rd[2]),
        .src0_dat_i(src_dat[0]), .src1_dat_i(src_dat[1]), .src2_dat_i(src_dat[2]),
`ifdef WB_ARB_FWD_EN
        .fwd_rs1_i(fwd_rs1), .fwd_rs2_i(fwd_rs2),
        .fwd_rs1_hit_o(hit1), .fwd_rs2_hit_o(hit2), .fwd_dat_o(fwd_dat),
`endif
        .reg_des_o(reg_des), .reg_des_dat_o(reg_dat), .wr_en_o(wr_en),
        .conflict_cnt_o(cnt)
    );

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .src0_valid_i(vld[0]), .src1_valid_i(vld[1]), .src2_valid_i(vld[2]),
        .src0_ready_o(rdy4[0]), .src1_ready_o(rdy4[1]), .src2_ready_o(rdy4[2]),
        .src0_rd_i(src_rd[0]), .src1_rd_i(src_rd[1]), .src2_rd_i(src_rd[2]),
        .src0_dat_i(src_dat[0]), .src1_dat_i(src_dat[1]), .src2_dat_i(src_dat[2]),
`ifdef WB_ARB_FWD_EN
        .fwd_rs1_i(fwd_rs1), .fwd_rs2_i(fwd_rs2),
        .fwd_rs1_hit_o(hit1_4), .fwd_rs2_hit_o(hit2_4), .fwd_dat_o(fwd_dat4),
`endif
        .reg_des_o(reg_des4), .reg_des_dat_o(reg_dat4), .wr_en_o(wr_en4),
        .conflict_cnt_o(cnt4)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Asserts reset wherever we are, checks the immediate outputs, releases just after an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(rdy), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_reg_des", 64'(reg_des), 64'd0);
        chk("rst_reg_dat", 64'(reg_dat), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_cnt4", 64'(cnt4), 64'd0);
        exp_q.delete();
        m_we = 1'b0; m_rd = '0; m_dat = '0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One cycle: drive valids, check the grant, push the expected write, compare after the edge.
    task automatic step(input logic [2:0] v, input int eg);
        logic [QW-1:0] e;
        logic [2:0]    exp_rdy;
        int            nv;
        vld = v;
        @(negedge clk);
        exp_rdy = (eg == 3) ? 3'b000 : 3'(1 << eg);
        chk("ready", 64'(rdy), 64'(exp_rdy));
        if (eg != 3) begin
            m_rd  = src_rd[eg];
            m_dat = src_dat[eg];
            m_we  = (m_rd != '0);
        end else begin
            m_we = 1'b0;
        end
        nv = int'(v[0]) + int'(v[1]) + int'(v[2]);
        if (nv >= 2) m_cnt++;
        exp_q.push_back({m_we, m_rd, m_dat, CW'(m_cnt)});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("wr_en", 64'(wr_en), 64'(e[QW-1]));
            chk("reg_des", 64'(reg_des), 64'(e[QW-2 -: AW]));
            chk("reg_dat", 64'(reg_dat), 64'(e[CW+DW-1 -: DW]));
            chk("conflict_cnt", 64'(cnt), 64'(e[CW-1:0]));
            chk("conflict_cnt4", 64'(cnt4), 64'((m_cnt > 15) ? 15 : m_cnt));
`ifdef WB_ARB_FWD_EN
            chk("fwd_hit1", 64'(hit1), 64'(e[QW-1] && (fwd_rs1 == e[QW-2 -: AW]) && (fwd_rs1 != '0)));
            chk("fwd_hit2", 64'(hit2), 64'(e[QW-1] && (fwd_rs2 == e[QW-2 -: AW]) && (fwd_rs2 != '0)));
            chk("fwd_dat", 64'(fwd_dat), 64'(e[CW+DW-1 -: DW]));
`endif
        end
    endtask

    typedef struct {
        logic [2:0]        v;
        logic [2:0][AW-1:0] rd;
        logic [2:0][DW-1:0] dat;
        int                eg;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] v, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                                input logic [AW-1:0] r2, input logic [DW-1:0] d0,
                                input logic [DW-1:0] d1, input logic [DW-1:0] d2, input int eg);
        vec_t t;
        t.v = v;
        t.rd[0] = r0; t.rd[1] = r1; t.rd[2] = r2;
        t.dat[0] = d0; t.dat[1] = d1; t.dat[2] = d2;
        t.eg = eg;
        return t;
    endfunction

    vec_t tbl[16];

    initial begin
        // valid vector is {src2, src1, src0}; eg 3 means no grant
        tbl[0]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 0);
        tbl[1]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 1);
        tbl[2]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 2);
        tbl[3]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111112, 32'h22222223, 32'h33333334, 0);
        tbl[4]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111112, 32'h22222223, 32'h33333334, 1);
        tbl[5]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111112, 32'h22222223, 32'h33333334, 2);
        tbl[6]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3);
        tbl[7]  = mk(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h00001234, 32'h0, 1);
        tbl[8]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3);
        tbl[9]  = mk(3'b101, 5'd1, 5'd0, 5'd7, 32'hCAFE0001, 32'h0, 32'hA5A5A5A5, 2);
        tbl[10] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3);
        tbl[11] = mk(3'b110, 5'd0, 5'd8, 5'd9, 32'h0, 32'hBEEF0008, 32'hBEEF0009, 1);
        tbl[12] = mk(3'b011, 5'd10, 5'd11, 5'd0, 32'hBEEF000A, 32'hBEEF000B, 32'h0, 0);
        tbl[13] = mk(3'b100, 5'd0, 5'd0, 5'd31, 32'h0, 32'h0, 32'hFFFFFFFF, 2);
        tbl[14] = mk(3'b001, 5'd12, 5'd0, 5'd0, 32'h0000000C, 32'h0, 32'h0, 0);
        tbl[15] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3);

        vld = '0;
        for (int i = 0; i < 3; i++) begin
            src_rd[i]  = '0;
            src_dat[i] = '0;
        end
`ifdef WB_ARB_FWD_EN
        fwd_rs1 = 5'd7;
        fwd_rs2 = 5'd8;
`endif
        do_reset();

        // single src0 result: accept, one-cycle write, then idle
        src_rd[0] = 5'd5; src_dat[0] = 32'hDEADBEEF;
        step(3'b001, 0);
        step(3'b000, 3);
        step(3'b000, 3);

        // table: rotation, x0 drop, mixed contention, forwarding
        do_reset();
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < 3; s++) begin
                src_rd[s]  = tbl[i].rd[s];
                src_dat[s] = tbl[i].dat[s];
            end
            step(tbl[i].v, tbl[i].eg);
        end

        // reset while a write is registered and src2 is presenting
        src_rd[0] = 5'd4; src_dat[0] = 32'h44444444;
        step(3'b001, 0);
        src_rd[2] = 5'd6; src_dat[2] = 32'h66666666;
        vld = 3'b100;
        #1;
        chk("pre_rst_ready", 64'(rdy), 64'd4);
        do_reset();
        step(3'b100, 2);
        step(3'b000, 3);

        // two sources held valid for 20 cycles: 16-bit counter reaches 20, 4-bit one stops at 15
        do_reset();
        src_rd[0] = 5'd13; src_dat[0] = $urandom_range(0, 32'h7FFFFFFF);
        src_rd[1] = 5'd14; src_dat[1] = $urandom_range(0, 32'h7FFFFFFF);
        for (int i = 0; i < 20; i++) step(3'b011, i % 2);
        step(3'b000, 3);
        chk("sat_cnt4_final", 64'(cnt4), 64'd15);
        chk("cnt_final", 64'(cnt), 64'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
